// File: rtl/led_pwm_ctrl_pkg.sv
// Shared types for the LED PWM controller: the channel mode encoding and the
// per-channel lighting decision used by the top level.
package led_pwm_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        PWM   = 2'd2,
        BLINK = 2'd3
    } mode_e;

    // Decide whether a channel is lit in normal (non-trap) operation.
    function automatic logic channel_lit(input mode_e mode,
                                         input logic  pwm_hit,
                                         input logic  blink_phase);
        logic lit;
        case (mode)
            OFF:     lit = 1'b0;
            ON:      lit = 1'b1;
            PWM:     lit = pwm_hit;
            BLINK:   lit = blink_phase & pwm_hit;
            default: lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// CPU-side register bus of the LED PWM controller, plus the trap indication
// that travels with it from the SoC.
interface led_pwm_ctrl_if #(
    parameter int CHANNELS = 5,
    parameter int PWM_BITS = 8
);
    localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                  wr_i;
    logic [AW-1:0]         addr_i;
    logic [PWM_BITS+1:0]   wdata_i;
    logic [PWM_BITS+1:0]   rdata_o;
    logic                  trap_i;

    modport master (
        output wr_i,
        output addr_i,
        output wdata_i,
        output trap_i,
        input  rdata_o
    );

    modport slave (
        input  wr_i,
        input  addr_i,
        input  wdata_i,
        input  trap_i,
        output rdata_o
    );

endinterface

// File: rtl/led_prescaler.sv
// Blink prescaler: toggles phase every HALF clock cycles and pulses tick for
// one cycle on each toggle. Both outputs are registered.
module led_prescaler #(
    parameter int HALF = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic phase,
    output logic tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    generate
        if (HALF < 1) begin : g_bad_half
            $error("led_prescaler: HALF must be at least 1");
        end
    endgenerate

    logic [CW-1:0] cnt_r;
    logic          phase_r;
    logic          tick_r;

    // Count HALF cycles, then wrap, flip the phase and emit a tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= 1'b0;
            tick_r  <= 1'b0;
        end else if (cnt_r == CW'(HALF - 1)) begin
            cnt_r   <= {CW{1'b0}};
            phase_r <= ~phase_r;
            tick_r  <= 1'b1;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
            tick_r  <= 1'b0;
        end
    end

    assign phase = phase_r;
    assign tick  = tick_r;

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED PWM controller: a small register file of {mode, duty} per channel, a
// free-running PWM counter, a blink prescaler and a trap override that makes
// every LED blink in unison. LED pins are registered with selectable polarity.
module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int CHANNELS   = 5,
    parameter int PWM_BITS   = 8,
    parameter int MCU_FREQ   = 16_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    led_pwm_ctrl_if.slave        bus,
    output logic [CHANNELS-1:0]  led_o
);

    localparam int AW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int RW   = PWM_BITS + MODE_W;
    localparam int HALF = MCU_FREQ / (2 * BLINK_HZ);
    localparam logic [CHANNELS-1:0] DARK =
        (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

    generate
        if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
            $error("led_pwm_ctrl: CHANNELS must be in 1..16");
        end
        if (HALF < 1) begin : g_bad_half
            $error("led_pwm_ctrl: MCU_FREQ/(2*BLINK_HZ) must be at least 1");
        end
    endgenerate

    logic [RW-1:0]        chan_r [CHANNELS];
    logic [PWM_BITS-1:0]  pwm_cnt_r;
    logic [CHANNELS-1:0]  led_r;
    logic [CHANNELS-1:0]  lit_s;
    logic [RW-1:0]        rdata_s;
    logic                 blink_phase_s;
    logic                 blink_tick_unused_s;

    // Channel register file; out-of-range addresses match no channel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                chan_r[i] <= {RW{1'b0}};
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.wr_i && (bus.addr_i == AW'(i))) begin
                    chan_r[i] <= bus.wdata_i;
                end
            end
        end
    end

    // Combinational readback of the addressed channel, zero when out of range.
    always_comb begin
        rdata_s = {RW{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            rdata_s = (bus.addr_i == AW'(i)) ? chan_r[i] : rdata_s;
        end
    end

    assign bus.rdata_o = rdata_s;

    // Free-running PWM counter, wraps naturally at 2^PWM_BITS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_cnt_r <= {PWM_BITS{1'b0}};
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
        end
    end

    led_prescaler #(
        .HALF (HALF)
    ) u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .phase (blink_phase_s),
        .tick  (blink_tick_unused_s)
    );

    // Per-channel lit decision; a trap overrides every mode with the blink phase.
    always_comb begin
        lit_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.trap_i) begin
                lit_s[i] = blink_phase_s;
            end else begin
                lit_s[i] = channel_lit(mode_e'(chan_r[i][RW-1:PWM_BITS]),
                                       (pwm_cnt_r < chan_r[i][PWM_BITS-1:0]),
                                       blink_phase_s);
            end
        end
    end

    // Registered LED pins with output polarity applied; dark during reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_r <= DARK;
        end else begin
            led_r <= lit_s ^ DARK;
        end
    end

    assign led_o = led_r;

endmodule
